// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN datapath: default widths, the Q-value type
// carried between the adder pipeline and the argmax stage, and the argmax
// stage's state encoding.
package dqn_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int NUM_ACTIONS_DEF = 4;

    // One Q-value as produced by the constant-offset adder pipeline.
    typedef logic [DATA_W_DEF-1:0] q_t;

    // COLLECT gathers one vector; HOLD presents the result until taken.
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } argmax_state_e;

    // Unsigned strict greater-than on default-width Q-values.
    function automatic logic q_gt(input q_t a, input q_t b);
        return a > b;
    endfunction

endpackage

// File: rtl/q_argmax.sv
// Greedy-action selector: collects NUM_ACTIONS consecutive unsigned Q-values
// (action order 0..NUM_ACTIONS-1) and reports the index and value of the
// largest one over a valid/ready handshake. Ties keep the lower index.
// A sticky err flags any disagreement between in_last and the beat counter;
// the counter alone decides where a vector ends.
module q_argmax
    import dqn_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NUM_ACTIONS = NUM_ACTIONS_DEF,
    parameter int IDX_W       = $clog2(NUM_ACTIONS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_action,
    output logic [DATA_W-1:0] out_qmax,
    output logic              err
);

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_ACTIONS - 1);

    argmax_state_e     state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  act_q, act_d;
    logic [DATA_W-1:0] qmax_q, qmax_d;
    logic              err_q, err_d;

    logic              accept;
    logic              last_beat;
    logic              take;
    logic [DATA_W-1:0] cand_max;
    logic [IDX_W-1:0]  cand_idx;

    // State register: every flop of the block, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            act_q   <= '0;
            qmax_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            qmax_q  <= qmax_d;
            err_q   <= err_d;
        end
    end

    // Next-state: running compare-and-select, beat counting, framing check.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        idx_d   = idx_q;
        act_d   = act_q;
        qmax_d  = qmax_q;
        err_d   = err_q;

        accept    = in_valid && (state_q == COLLECT);
        last_beat = (cnt_q == LAST_BEAT);
        // Beat 0 seeds the running max; later beats need a strict win.
        take      = (cnt_q == '0) || (in_data > max_q);
        cand_max  = take ? in_data : max_q;
        cand_idx  = take ? cnt_q   : idx_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    max_d = cand_max;
                    idx_d = cand_idx;
                    if (in_last != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        qmax_d  = cand_max;
                        act_d   = cand_idx;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Outputs: handshake flags decoded from state, result and err from flops.
    always_comb begin
        in_ready   = (state_q == COLLECT);
        out_valid  = (state_q == HOLD);
        out_action = act_q;
        out_qmax   = qmax_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_q_argmax.sv
// Directed bench for q_argmax: a table of complete vectors with hand-computed
// results, then hand-written sequences for backpressure, bubbles,
// back-to-back vectors, reset mid-vector and framing errors.
module tb_q_argmax;

    localparam int DW = 32;
    localparam int NA = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_action;
    logic [DW-1:0] out_qmax;
    logic          err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] v [NA];
        logic [IW-1:0] act;
        logic [DW-1:0] qmax;
    } vec_t;

    vec_t tbl [7];

    q_argmax #(.DATA_W(DW), .NUM_ACTIONS(NA)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_action (out_action),
        .out_qmax   (out_qmax),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Checks right after the final beat of a vector is accepted.
    task automatic check_result(input string tag, input logic [IW-1:0] a, input logic [DW-1:0] q);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
        check({tag, "_action"},    {30'd0, out_action}, {30'd0, a});
        check({tag, "_qmax"},      out_qmax, q);
    endtask

    initial begin
        logic [DW-1:0] seq [8];
        logic [IW-1:0] res_a [$];
        logic [DW-1:0] res_q [$];
        int idx;
        int idle;

        tbl[0].v = '{32'd8, 32'd3, 32'd15, 32'd15};         tbl[0].act = 2'd2; tbl[0].qmax = 32'd15;
        tbl[1].v = '{32'd0, 32'd0, 32'd0, 32'd0};           tbl[1].act = 2'd0; tbl[1].qmax = 32'd0;
        tbl[2].v = '{32'd4, 32'd3, 32'd2, 32'd1};           tbl[2].act = 2'd0; tbl[2].qmax = 32'd4;
        tbl[3].v = '{32'd1, 32'd2, 32'd3, 32'd4};           tbl[3].act = 2'd3; tbl[3].qmax = 32'd4;
        tbl[4].v = '{32'd7, 32'd7, 32'd7, 32'd7};           tbl[4].act = 2'd0; tbl[4].qmax = 32'd7;
        tbl[5].v = '{32'd5, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFF}; tbl[5].act = 2'd1; tbl[5].qmax = 32'hFFFF_FFFF;
        tbl[6].v = '{32'd2, 32'd1, 32'd0, 32'd3};           tbl[6].act = 2'd3; tbl[6].qmax = 32'd3;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state.
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_action",    {30'd0, out_action}, 32'd0);
        check("rst_qmax",      out_qmax, 32'd0);
        check("rst_err",       {31'd0, err}, 32'd0);

        // Table of complete vectors, out_ready held high.
        for (int t = 0; t < 7; t++) begin
            for (int b = 0; b < NA; b++) send_beat(tbl[t].v[b], b == NA - 1);
            check_result($sformatf("tbl%0d", t), tbl[t].act, tbl[t].qmax);
            check($sformatf("tbl%0d_err", t), {31'd0, err}, 32'd0);
            step();
            check($sformatf("tbl%0d_drop", t), {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: result held while out_ready=0, waiting value not consumed.
        out_ready = 1'b0;
        send_beat(32'd1, 1'b0);
        send_beat(32'd9, 1'b0);
        send_beat(32'd4, 1'b0);
        send_beat(32'd2, 1'b1);
        in_valid = 1'b1; in_data = 32'd7; in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_result($sformatf("bp_hold%0d", c), 2'd1, 32'd9);
            step();
        end
        out_ready = 1'b1;
        check_result("bp_release", 2'd1, 32'd9);
        step();
        check("bp_out_valid_low", {31'd0, out_valid}, 32'd0);
        check("bp_in_ready_back", {31'd0, in_ready},  32'd1);
        step();
        in_valid = 1'b0;
        send_beat(32'd1, 1'b0);
        send_beat(32'd1, 1'b0);
        send_beat(32'd1, 1'b1);
        check_result("bp_seven_first", 2'd0, 32'd7);
        step();

        // Bubbles and extreme values.
        send_beat(32'd0, 1'b0);
        repeat (3) step();
        send_beat(32'hFFFF_FFFF, 1'b0);
        step();
        send_beat(32'd0, 1'b0);
        send_beat(32'd5, 1'b1);
        check_result("bubble", 2'd1, 32'hFFFF_FFFF);
        step();

        // Back-to-back vectors with in_valid held high.
        seq = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4};
        idx = 0;
        idle = 0;
        for (int c = 0; c < 16; c++) begin
            if (out_valid) begin
                res_a.push_back(out_action);
                res_q.push_back(out_qmax);
            end
            if (idx < 8) begin
                in_valid = 1'b1;
                in_data  = seq[idx];
                in_last  = (idx % 4 == 3);
                if (!in_ready) idle++;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            if (in_valid && in_ready) begin
                step();
                idx++;
            end else begin
                step();
            end
        end
        in_valid = 1'b0;
        check("b2b_results", res_a.size(), 32'd2);
        check("b2b_idle",    idle, 32'd1);
        if (res_a.size() == 2) begin
            check("b2b_a0", {30'd0, res_a[0]}, 32'd0);
            check("b2b_q0", res_q[0], 32'd4);
            check("b2b_a1", {30'd0, res_a[1]}, 32'd3);
            check("b2b_q1", res_q[1], 32'd4);
        end

        // Reset mid-vector discards partial beats.
        send_beat(32'd50, 1'b0);
        send_beat(32'd60, 1'b0);
        do_reset();
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        send_beat(32'd3, 1'b0);
        send_beat(32'd4, 1'b1);
        check_result("midrst", 2'd3, 32'd4);
        check("midrst_err", {31'd0, err}, 32'd0);
        step();

        // Missing in_last on the final beat.
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        send_beat(32'd3, 1'b0);
        check("nolast_err_before", {31'd0, err}, 32'd0);
        send_beat(32'd4, 1'b0);
        check("nolast_err", {31'd0, err}, 32'd1);
        check_result("nolast", 2'd3, 32'd4);
        step();
        do_reset();
        check("nolast_err_cleared", {31'd0, err}, 32'd0);

        // Early in_last on beat 1: err sets, vector still completes after 4 beats.
        send_beat(32'd10, 1'b0);
        send_beat(32'd20, 1'b1);
        check("early_err", {31'd0, err}, 32'd1);
        check("early_no_result", {31'd0, out_valid}, 32'd0);
        send_beat(32'd30, 1'b0);
        send_beat(32'd40, 1'b1);
        check_result("early", 2'd3, 32'd40);
        repeat (3) step();
        check("early_err_sticky", {31'd0, err}, 32'd1);
        do_reset();
        check("early_err_cleared", {31'd0, err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/q_argmax.md
Name: q_argmax

Overview:
- Downstream consumer of the constant-offset adder pipeline's 32-bit result stream.
- Collects NUM_ACTIONS consecutive Q-values, one action per accepted beat, in action order 0..NUM_ACTIONS-1.
- Emits the index of the largest value (greedy action) and that value over a valid/ready handshake.
- Feeds the action-selection / replay logic of the DQN datapath.

Parameters:
- DATA_W, 32, width of each Q-value (unsigned).
- NUM_ACTIONS, 4, values per vector; legal range 2..256.
- IDX_W, $clog2(NUM_ACTIONS), width of the action index and beat counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream value present.
- in_ready  out  1  block accepts a value this cycle.
- in_data  in  DATA_W  Q-value for action = current beat count.
- in_last  in  1  upstream marks final value of a vector.
- out_valid  out  1  result available.
- out_ready  in  1  downstream takes result.
- out_action  out  IDX_W  argmax index.
- out_qmax  out  DATA_W  maximum Q-value.
- err  out  1  sticky framing error.

Behaviour:
- Reset (rst=1 at a clk edge), regardless of state or partial vector:
  - state=COLLECT, beat count=0, running max=0, running index=0.
  - out_valid=0, out_action=0, out_qmax=0, err=0.
  - Any partial vector is discarded.
- Accept = in_valid & in_ready.
- State COLLECT:
  - in_ready=1, out_valid=0.
  - Each accept compares in_data against the running max as an unsigned DATA_W comparison; no arithmetic, no widening.
  - Beat 0 loads max=in_data and index=0 unconditionally.
  - Beat k>0 replaces max and index only if in_data > max (strict). Ties keep the lower index.
  - Count increments per accept; no change while in_valid=0 (bubbles allowed).
  - On accept with count==NUM_ACTIONS-1: load out_qmax/out_action from the final compare (including the current beat), set out_valid=1, go to HOLD, reset count to 0.
- State HOLD:
  - in_ready=0.
  - out_valid, out_action and out_qmax stay stable until out_ready=1.
  - On out_valid & out_ready: out_valid=0, go to COLLECT.
  - The next value can be accepted on the following cycle.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Throughput: at most one vector per NUM_ACTIONS+1 cycles.
- Framing check, on each accept:
  - in_last=1 with count!=NUM_ACTIONS-1 sets err=1.
  - in_last=0 with count==NUM_ACTIONS-1 sets err=1.
  - err is sticky until reset.
  - Vector collection is not altered; the counter is authoritative.
- out_ready while out_valid=0 is ignored.
- in_valid may be held high during HOLD; no value is consumed until COLLECT.
- Values equal to 0 or 2^DATA_W-1 need no special handling. A vector of all zeros yields action 0, qmax 0.

Decomposition:
- Shared package `dqn_pkg`:
  - DATA_W and NUM_ACTIONS defaults.
  - State enum {COLLECT, HOLD}.
  - Q-value typedef (logic [DATA_W-1:0]), also used by the adder pipeline.
- No sub-module needed; the compare-and-select is a single always block.
- Optional helper function `q_gt` in `dqn_pkg`.

Test Plan:
- Basic vector: send 8,3,15,15 (in_last on 4th), out_ready=1 → out_valid the cycle after beat 3, out_action=2, out_qmax=15 (tie keeps 2), err=0.
- Backpressure: send 1,9,4,2 with out_ready=0 for 5 cycles, in_valid held high with 7 → in_ready=0 throughout HOLD, outputs stable at action 1 / qmax 9, value 7 consumed only after out_ready.
- Bubbles and extremes: send 0, gap 3 cycles, FFFFFFFF, gap, 0, 5 → action 1, qmax FFFFFFFF; all-zero vector → action 0, qmax 0.
- Framing error: in_last asserted on beat 1 → err=1 from next cycle, vector still completes after 4 beats, err stays 1 until rst.
- Reset mid-operation: accept 2 beats (50,60), assert rst one cycle, then send 1,2,3,4 → out_action=3, out_qmax=4, the 50/60 beats have no effect, err=0.
- Back-to-back: consecutive vectors 4,3,2,1 and 1,2,3,4 with out_ready=1 → results (0,4) then (3,4), each exactly once, one idle in_ready=0 cycle between vectors.
